// File: rtl/cla_pipe_addsub.sv
// ---------------------------------------------------------------------------
// cla_pipe_addsub -- pipelined carry-lookahead adder/subtractor
//
// A WIDTH-bit add or subtract is split into NG = WIDTH/GROUP lookahead
// groups. Each pipeline stage resolves one group, and the group carry is
// registered between stages. The result is A + B + cin (sub=0) or
// A + ~B + cin (sub=1). Throughput is one beat per cycle. A beat accepted
// at edge N appears on the outputs after edge N+NG-1.
//
// Optional feature (compile-time macro CLA_ADDSUB_SAT_EN):
//   When defined, this adds the input 'sat'. If sat=1 and the result
//   overflows, sum is clamped to the most-positive or most-negative value.
//   When undefined, sum always wraps modulo 2^WIDTH.
//
// Parameters:
//   WIDTH     operand/result width (must be a multiple of GROUP)
//   GROUP     bits per lookahead group, one group per stage (>= 1)
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   operand handshake (in_ready = pipeline advances)
//   a, b, cin, sub      operands, carry-in, subtract select
//   sat                 saturate on overflow (CLA_ADDSUB_SAT_EN only)
//   out_valid/out_ready result handshake
//   sum, cout, ovf      result, carry out of MSB, signed overflow
// ---------------------------------------------------------------------------

// One lookahead group. Every internal carry is built as a flat
// sum-of-products of G/P terms and the group carry-in. No c[i] feeds
// c[i+1], so the depth stays constant rather than growing with GROUP.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] bx,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  always_comb begin
    logic pr;
    logic cc;
    p    = a ^ bx;
    g    = a & bx;
    c    = '0;
    c[0] = ci;
    pr   = 1'b0;
    cc   = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      // c[i+1] = G[i] | P[i]G[i-1] | ... | P[i]..P[0]ci
      pr = 1'b1;
      cc = 1'b0;
      for (int j = i; j >= 0; j--) begin
        cc = cc | (g[j] & pr);
        pr = pr & p[j];
      end
      c[i+1] = cc | (pr & ci);
    end
    s  = p ^ c[GROUP-1:0];
    co = c[GROUP];
  end

endmodule

module cla_pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef CLA_ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GSAFE = (GROUP < 1) ? 1 : GROUP;
  localparam int NG    = WIDTH / GSAFE;

  if ((GROUP < 1) || (WIDTH < 1) || ((WIDTH % GSAFE) != 0)) begin : g_bad_param
    $error("cla_pipe_addsub: WIDTH must be a positive multiple of GROUP, GROUP >= 1");
  end

`ifdef CLA_ADDSUB_SAT_EN
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0] SMAX = ~SMIN;
`endif

  logic [WIDTH-1:0] bx_in;
  logic             adv;

  // Subtraction is A + ~B + cin. cin=1 gives the usual two's-complement
  // subtract, and cin=0 gives subtract-with-borrow.
  assign bx_in    = sub ? ~b : b;

  // The whole pipe moves as one. It stalls only when a valid result is
  // waiting on the output and downstream refuses it. A bubble on the
  // output never blocks, so bubbles flow through uncompressed.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar k = 1; k <= NG; k++) begin : g_stg
    localparam int DONE = k * GROUP;   // bits resolved once this stage loads

    logic [GROUP-1:0] ga, gbx, gs;
    logic             gci, gco, vld_in;
    logic [DONE-1:0]  sum_raw;
`ifdef CLA_ADDSUB_SAT_EN
    logic             sat_in;
`endif
    logic [DONE-1:0]  sum_d, sum_q;
    logic             co_d, co_q;
    logic             vld_d, vld_q;

    // Stage 1 takes its group directly from the ports. Later stages take
    // the lowest unprocessed group from the previous stage's skew
    // registers.
    if (k == 1) begin : g_src
      assign ga      = a[GROUP-1:0];
      assign gbx     = bx_in[GROUP-1:0];
      assign gci     = cin;
      assign vld_in  = in_valid;
      assign sum_raw = gs;
`ifdef CLA_ADDSUB_SAT_EN
      assign sat_in  = sat;
`endif
    end else begin : g_src
      assign ga      = g_stg[k-1].g_mid.a_q[GROUP-1:0];
      assign gbx     = g_stg[k-1].g_mid.bx_q[GROUP-1:0];
      assign gci     = g_stg[k-1].co_q;
      assign vld_in  = g_stg[k-1].vld_q;
      assign sum_raw = {gs, g_stg[k-1].sum_q};
`ifdef CLA_ADDSUB_SAT_EN
      assign sat_in  = g_stg[k-1].g_mid.sat_q;
`endif
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .a  (ga),
      .bx (gbx),
      .ci (gci),
      .s  (gs),
      .co (gco)
    );

    if (k < NG) begin : g_mid
      // Skew registers hold only the operand bits that later stages
      // still need. The register shrinks by GROUP bits per stage.
      localparam int REM = WIDTH - DONE;
      logic [REM-1:0] a_d, a_q, bx_d, bx_q;
      logic           sat_d, sat_q;

      if (k == 1) begin : g_rsrc
        always_comb begin
          a_d  = a[WIDTH-1:DONE];
          bx_d = bx_in[WIDTH-1:DONE];
        end
      end else begin : g_rsrc
        always_comb begin
          a_d  = g_stg[k-1].g_mid.a_q[REM+GROUP-1:GROUP];
          bx_d = g_stg[k-1].g_mid.bx_q[REM+GROUP-1:GROUP];
        end
      end

      always_comb begin
        sum_d = sum_raw;
        co_d  = gco;
        vld_d = vld_in;
`ifdef CLA_ADDSUB_SAT_EN
        sat_d = sat_in;
`else
        sat_d = 1'b0;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          bx_q  <= '0;
          sat_q <= 1'b0;
        end else if (adv) begin
          a_q   <= a_d;
          bx_q  <= bx_d;
          sat_q <= sat_d;
        end
      end
    end else begin : g_last
      logic ovf_d, ovf_q;

      always_comb begin
        // Carry into the MSB is recovered from P^S at that bit. That saves
        // exporting one more internal carry from the group.
        ovf_d = ga[GROUP-1] ^ gbx[GROUP-1] ^ gs[GROUP-1] ^ gco;
        sum_d = sum_raw;
        co_d  = gco;
        vld_d = vld_in;
`ifdef CLA_ADDSUB_SAT_EN
        // On overflow the true result has the sign of operand A, so A's
        // sign picks the clamp rail.
        if (sat_in && ovf_d) sum_d = ga[GROUP-1] ? SMIN : SMAX;
`endif
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ovf_q <= 1'b0;
        else if (adv) ovf_q <= ovf_d;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        co_q  <= 1'b0;
        vld_q <= 1'b0;
      end else if (adv) begin
        sum_q <= sum_d;
        co_q  <= co_d;
        vld_q <= vld_d;
      end
    end
  end

  assign out_valid = g_stg[NG].vld_q;
  assign sum       = g_stg[NG].sum_q;
  assign cout      = g_stg[NG].co_q;
  assign ovf       = g_stg[NG].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub (WIDTH=16, GROUP=4).
//
// Expected results go into a queue at the point of acceptance. A monitor
// pops the queue whenever a result transfers. The reference model is plain
// integer arithmetic.
module tb_cla_pipe_addsub;
  localparam int WIDTH = 16;
  localparam int GROUP = 4;
  localparam int NG    = WIDTH / GROUP;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             cin = 1'b0, sub = 1'b0, sat = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf;

  exp_t sbq[$];
  int   n_cmp = 0, n_bad = 0, n_in = 0, n_out = 0;
  bit   rnd_done;

`ifdef CLA_ADDSUB_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(WIDTH), .GROUP(GROUP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef CLA_ADDSUB_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the operands as written.
  function automatic exp_t model(input logic [15:0] ia, ib, input logic icin, isub, isat);
    logic [15:0] bx;
    logic [16:0] u;
    int          s;
    exp_t        e;
    bx     = isub ? ~ib : ib;
    u      = {1'b0, ia} + {1'b0, bx} + {16'd0, icin};
    s      = int'($signed(ia)) + int'($signed(bx)) + int'(icin);
    e.sum  = u[15:0];
    e.cout = u[16];
    e.ovf  = (s > 32767) || (s < -32768);
    if (isat && e.ovf) e.sum = (s > 0) ? 16'h7FFF : 16'h8000;
    return e;
  endfunction

  // Present one beat and hold it until it is accepted (bounded).
  task automatic send(input logic [15:0] ia, ib, input logic icin, isub, isat, input exp_t e);
    bit acc;
    int t;
    in_valid = 1'b1; a = ia; b = ib; cin = icin; sub = isub; sat = isat;
    acc = 1'b0; t = 0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready && rst_n;
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (acc) begin
      sbq.push_back(e);
      n_in++;
    end else check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic send_rand();
    logic [15:0] ra, rb;
    logic        rc, rs, rt;
    ra = 16'($urandom); rb = 16'($urandom);
    rc = 1'($urandom); rs = 1'($urandom);
    rt = SAT_EN ? 1'($urandom) : 1'b0;
    send(ra, rb, rc, rs, rt, model(ra, rb, rc, rs, rt));
  endtask

  task automatic drain();
    int t = 0;
    while (sbq.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
  endtask

  // After a lone beat accepted at edge N, out_valid must rise only after
  // edge N+NG-1.
  task automatic check_latency(input string nm);
    for (int j = 1; j < NG; j++) begin
      @(posedge clk); #1;
      check(nm, 32'(out_valid), 32'(j == NG - 1));
    end
  endtask

  // Monitor: pops on every transfer and checks that outputs hold while
  // stalled.
  initial begin
    exp_t        e;
    logic [17:0] held;
    bit          stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) stalled = 1'b0;
      else begin
        if (out_valid && !out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (stalled) check("stall_hold", 32'({sum, cout, ovf}), 32'(held));
          stalled = 1'b1;
          held    = {sum, cout, ovf};
        end else stalled = 1'b0;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) check("unexpected_result", 32'({sum, cout, ovf}), 32'h0);
          else begin
            e = sbq.pop_front();
            check("result", 32'({sum, cout, ovf}), 32'(e));
            n_out++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t dir[6];
    dir[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    dir[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    dir[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    dir[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    dir[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    dir[5] = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

    // Reset held over edges while in_valid is high.
    #1 rst_n = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #1 check("rel_in_ready", 32'(in_ready), 32'd1);
    repeat (NG + 1) begin
      @(posedge clk); #1;
      check("rel_idle", 32'(out_valid), 32'd0);
    end

    // Directed single beats with latency check.
    foreach (dir[i]) begin
      send(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub, 1'b0,
           '{sum: dir[i].s, cout: dir[i].co, ovf: dir[i].ov});
      check_latency("latency");
      drain();
    end

    // Back-to-back stream, then the same stream with a 3-cycle stall.
    for (int i = 1; i <= 8; i++)
      send(16'(i), 16'(i * 16'h0100), 1'b0, 1'b0, 1'b0,
           '{sum: 16'(i * 16'h0101), cout: 1'b0, ovf: 1'b0});
    fork
      for (int i = 9; i <= 16; i++)
        send(16'(i), 16'(i * 16'h0100), 1'b0, 1'b0, 1'b0,
             '{sum: 16'(i * 16'h0101), cout: 1'b0, ovf: 1'b0});
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random gaps and random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_rand();
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Async reset with three beats in flight and the head result stalled.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++)
      send(16'(16'h0F00 + i), 16'h0011, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    n_in -= sbq.size();
    sbq.delete();
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_sum", 32'(sum), 32'd0);
    check("async_rst_cout", 32'(cout), 32'd0);
    out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (NG + 2) begin
      @(posedge clk); #1;
      check("post_rst_idle", 32'(out_valid), 32'd0);
    end
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
    check_latency("post_rst_latency");
    drain();

`ifdef CLA_ADDSUB_SAT_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{sum: 16'h7FFF, cout: 1'b0, ovf: 1'b1});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, '{sum: 16'h8000, cout: 1'b1, ovf: 1'b1});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1});
    drain();
`endif

    check("sb_empty", 32'(sbq.size()), 32'd0);
    check("beat_count", 32'(n_out), 32'(n_in));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor.
- Splits a WIDTH-bit operation into WIDTH/GROUP lookahead groups and computes one group per pipeline stage, with the group carry registered between stages.
- Valid/ready handshake on input and output. Used wherever the datapath needs wide add/sub at full clock rate, one operation per cycle.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per carry-lookahead group (one group per stage); must be >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts a beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in (borrow-not in subtract mode)
- sub  input  1  0: A+B+cin; 1: A+~B+cin
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (sub: 1 = no borrow)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: one clock; rst_n is asynchronous, active-low. While rst_n=0, all stage valid bits, data, skew and carry registers clear immediately. Outputs: out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once reset is released.
- NG = WIDTH/GROUP stages. Illegal parameters (WIDTH % GROUP != 0 or GROUP < 1) cause an elaboration error.
- Operand prep: bx = sub ? ~b : b, combinational at the input.
- Per-group arithmetic: P = a^bx, G = a&bx. Full in-group lookahead: c[i+1] = G[i] | P[i]&c[i], expanded, not rippled. sum bit = P ^ c.
- Stage k (k = 1..NG) registers:
  - completed sum bits of groups 0..k-1
  - the group-(k-1) carry out
  - skewed unprocessed bits of a and bx for groups k..NG-1
  - the valid bit
- Stage 1 is loaded from the ports on accept. Stage NG drives sum, cout, out_valid.
- ovf = carry into MSB XOR carry out of MSB. It is registered alongside cout in stage NG.
- Advance: adv = out_ready | ~out_valid. in_ready = adv.
  - When adv=1, all stages shift one place. Stage 1 loads the input beat if in_valid=1, otherwise a bubble (valid=0).
  - When adv=0, every register holds, and sum/cout/ovf stay stable while out_valid=1.
- Latency: a beat accepted at rising edge N has its result presented with out_valid=1 after edge N+NG-1, provided no stall occurs. The beat accepted at edge N counts as cycle 1.
- Throughput: one beat per cycle with out_ready held at 1. Bubbles are not compressed. Results are returned in acceptance order.
- Simultaneous accept and output: when out_valid=1, out_ready=1 and in_valid=1 in the same cycle, both transfers happen and the pipeline shifts.
- Wrap-around: sum is modulo 2^WIDTH unless saturation is enabled (see below).
- Reset mid-stream: all in-flight beats are discarded. No stale result appears after rst_n is released.

Optional Feature:
- Macro: CLA_ADDSUB_SAT_EN.
- Defined:
  - Adds input port sat (1 bit), sampled with the operands and carried down the pipeline.
  - If sat=1 and ovf=1, sum is clamped: 2^(WIDTH-1)-1 when the true result is positive (operand A sign = 0), -2^(WIDTH-1) otherwise.
  - ovf still reports the overflow; cout is unchanged.
- Undefined: no sat port; sum always wraps; area and timing match the base block.

Test Plan:
- Reset: hold rst_n=0 over edges with in_valid=1 -> out_valid=0, sum=0x0000, cout=0, ovf=0. After release, in_ready=1.
- Add path (WIDTH=16, GROUP=4), each op an independent single beat:
  - a=0x00FF, b=0x0001, cin=0, sub=0 -> sum=0x0100, cout=0, ovf=0, out_valid after edge N+3.
  - a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
  - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract path (cin=1):
  - a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
  - a=0x1234, b=0x1234, sub=1 -> sum=0x0000, cout=1.
- Streaming/backpressure: 8 back-to-back beats a=i, b=0x0100·i (i=1..8) with out_ready=1 -> 8 consecutive results 0x0101·i in order. Then drop out_ready for 3 cycles mid-stream -> in_ready=0, sum held stable, no beat lost or duplicated.
- Async reset mid-stream: assert rst_n=0 between edges while 3 beats are in flight -> out_valid falls without waiting for an edge. After release, no result appears until a new beat has been accepted and NG cycles have passed.
- With CLA_ADDSUB_SAT_EN: sat=1 and a=0x7FFF, b=0x0001, sub=0 -> sum=0x7FFF, ovf=1. sat=1 and a=0x8000, b=0x0001, sub=1, cin=1 -> sum=0x8000, ovf=1. sat=0 -> results match the wrap-around values above.
